// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a counter that must reach max_hold; never narrower than one bit.
  function automatic int cnt_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req_masked, searching from
// ptr+1 upward and wrapping mod N. Purely combinational.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_masked,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] win_id,
  output logic [N-1:0]         win_onehot
);
  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             sel_s;
  int             idx_s;

  // Double the vector so a plain shift rotates ptr+1 down to bit 0, then
  // priority-encode and map the offset back to an absolute index.
  always_comb begin
    dbl_s = {req_masked, req_masked} >> (int'(ptr) + 1);
    rot_s = dbl_s[N-1:0];
    sel_s = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        sel_s = j;
      end else begin
        sel_s = sel_s;
      end
    end
    idx_s      = int'(ptr) + 1 + sel_s;
    idx_s      = (idx_s >= N) ? (idx_s - N) : idx_s;
    any        = |req_masked;
    win_id     = IW'(idx_s);
    win_onehot = N'(1'b1) << idx_s;
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with bounded burst ownership, immediate handover
// and registered one-hot grant, binary grant index and valid flag.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid
);
  localparam int             IW       = $clog2(N);
  localparam int             CW       = cnt_width(MAX_HOLD);
  localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [IW-1:0]  PTR_RST  = IW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  pick_in_s;
  logic          pick_any_s;
  logic [IW-1:0] pick_id_s;
  logic [N-1:0]  pick_oh_s;
  logic          owner_req_s;

  // While busy the owner is masked out, so the picker sees exactly "others".
  assign pick_in_s   = (state_q == BUSY) ? (req & ~gnt_q) : req;
  assign owner_req_s = |(req & gnt_q);

  rr_pick #(.N(N)) u_pick (
    .req_masked (pick_in_s),
    .ptr        (ptr_q),
    .any        (pick_any_s),
    .win_id     (pick_id_s),
    .win_onehot (pick_oh_s)
  );

  // Next-state and next-output decisions.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d  = BUSY;
          gnt_d    = pick_oh_s;
          gnt_id_d = pick_id_s;
          ptr_d    = pick_id_s;
          hold_d   = CW'(1);
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        if (owner_req_s && ((hold_q < HOLD_MAX) || !pick_any_s)) begin
          hold_d = (hold_q < HOLD_MAX) ? (hold_q + CW'(1)) : hold_q;
        end else if (pick_any_s) begin
          // Forced rotation and voluntary handover share the same winner.
          gnt_d    = pick_oh_s;
          gnt_id_d = pick_id_s;
          ptr_d    = pick_id_s;
          hold_d   = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
    valid_d = |gnt_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_RST;
      hold_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      valid_q  <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter granting one of N requesters a shared resource, with bounded grant hold (burst) and immediate handover. It is the next generation of the team's fixed 3-way rotating arbiter. It generalises the channel count and adds multi-cycle ownership, a binary grant index and a valid flag. It sits between N request sources and a single shared slave or bus port.

## Interface
- N, default 3: number of requesters; legal range N ≥ 2.
- MAX_HOLD, default 4: maximum consecutive cycles one owner keeps the grant while others are waiting; legal range MAX_HOLD ≥ 1.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  N  request vector, bit i = requester i; level-sensitive.
- gnt  output  N  registered one-hot grant, or all-zero.
- gnt_id  output  $clog2(N)  binary index of the current owner; holds the last owner when gnt_valid=0.
- gnt_valid  output  1  equals |gnt.

## Operation
- State: `IDLE` (no owner) and `BUSY` (owner k).
- Registers:
  - ptr: last winner, $clog2(N) bits.
  - hold_cnt: $clog2(MAX_HOLD+1) bits, saturating at MAX_HOLD.
  - gnt, gnt_id.
- Rotating priority: search starts at index ptr+1, increments mod N (wraps from N-1 to 0), and ends at ptr. The first set bit of the masked request vector wins.
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, ptr=N-1 (requester 0 has top priority first), state=`IDLE`.
- `IDLE`:
  - If req≠0: grant the winner w, set ptr←w and hold_cnt←1, go to `BUSY`.
  - Otherwise stay in `IDLE`.
- `BUSY`, owner k, others = req & ~(1<<k):
  - req[k]=1 and (hold_cnt<MAX_HOLD or others=0): keep the grant; hold_cnt←min(hold_cnt+1, MAX_HOLD).
  - req[k]=1, hold_cnt=MAX_HOLD, others≠0: forced rotation. Grant the winner of others, set ptr←winner and hold_cnt←1.
  - req[k]=0 and others≠0: handover with no idle cycle. Grant the winner of others, set ptr←winner and hold_cnt←1.
  - req[k]=0 and others=0: gnt←0, go to `IDLE`; ptr is retained and hold_cnt←0.
- A sole requester keeps the grant indefinitely, with hold_cnt saturated.
- When MAX_HOLD=1 and several requesters are active, the grant rotates every cycle, matching the legacy single-cycle behaviour.
- gnt is never multi-hot and never grants a requester whose req was 0 at the sampling edge.
- There is no request memory: a requester dropping req before being granted loses its turn silently.

## Timing
- Latency: req sampled at edge t drives gnt after edge t. There is one cycle from request to grant and no combinational path req→gnt.
- Handover: the old owner's gnt bit falls and the new owner's bit rises on the same edge, with zero dead cycles.
- Release: the owner drops req at edge t, so gnt=0 after edge t when no one else is requesting.
- Simultaneous events: the owner releasing while hold_cnt=MAX_HOLD is treated as a release. The winner is identical either way.
- Reset mid-grant: rst=1 at an edge forces all reset values after that edge, regardless of req. Arbitration resumes on the first edge with rst=0.
- Maximum wait for a continuously requesting input: (N-1)·MAX_HOLD cycles.

## Structure
- Package arb_pkg:
  - State enum arb_state_t {`IDLE`, `BUSY`}.
  - Function clog2-safe width helper for hold_cnt.
- Sub-module rr_pick (combinational, parameter N):
  - Inputs: req_masked[N-1:0] and ptr.
  - Outputs: any, win_id, win_onehot.
  - Implemented as a double-width request vector, a priority encoder and a rotate-back.
  - Instantiated once; `IDLE` and `BUSY` differ only in the mask applied to its input.
- Top: state register, ptr, hold_cnt, output registers.

## Test plan
- Reset: assert rst for 2 cycles with req=111 (N=3) → gnt=000, gnt_valid=0, gnt_id=0 during reset; gnt=001 one edge after release.
- Fair rotation: N=3, MAX_HOLD=1, req=111 constant → gnt sequence 001,010,100,001,… with no repeats and no gaps.
- Burst hold:
  - N=3, MAX_HOLD=4, req=011 constant → gnt=001 for 4 cycles, then 010 for 4, then 001.
  - req=001 alone for 10 cycles → gnt=001 throughout.
  - req[1] raised at cycle 10 → gnt=010 on the next edge.
- Handover and release:
  - Owner 0 drops req while req=101 → gnt=100 on the next edge, no idle cycle.
  - req→000 → gnt=000 next edge, and the next single request is granted per the retained ptr.
- Wrap and reset mid-operation:
  - N=5, ptr=4, req=10001 → gnt=00001.
  - Assert rst while gnt=00100 → gnt=00000 next edge; after release, req=11111 → gnt=00001.
- Random: constrained-random req for 10k cycles, N=5, MAX_HOLD=3 → scoreboard checks:
  - one-hot or zero gnt;
  - gnt ⊆ previous-edge req;
  - wait ≤ (N-1)·MAX_HOLD for held requests;
  - gnt_id consistent with gnt.
